// File: rtl/rr_lock_arbiter.sv
// Round-robin N-input valid/ready arbiter that holds the grant for BEATS-beat messages.
// Optional lock watchdog enabled by defining RR_LOCK_WATCHDOG_EN.
module rr_lock_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 64,
  parameter int unsigned BEATS   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*W-1:0]       in_bits,
  input  logic [N-1:0]         in_multibeat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_bits,
  output logic                 out_multibeat,
  output logic [$clog2(N)-1:0] out_chosen,
  output logic                 locked,
  output logic                 lock_timeout_err
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0] choice;
  logic          found;
  logic          fire;

  // Rotating priority: first valid above last_grant, else lowest valid, else N-1.
  always_comb begin
    choice = IW'(N - 1);
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && in_valid[i] && (IW'(i) > last_grant_q)) begin
        choice = IW'(i);
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && in_valid[i]) begin
        choice = IW'(i);
        found  = 1'b1;
      end
    end
  end

  assign locked        = (beat_cnt_q != '0);
  assign out_chosen    = locked ? lock_idx_q : choice;
  assign out_valid     = in_valid[out_chosen];
  assign out_multibeat = in_multibeat[out_chosen];
  assign fire          = out_valid & out_ready;

  always_comb begin
    out_bits = '0;
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (out_chosen == IW'(i)) begin
        out_bits    = in_bits[i*W +: W];
        in_ready[i] = out_ready;
      end
    end
  end

`ifdef RR_LOCK_WATCHDOG_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    last_grant_d = last_grant_q;
    lock_idx_d   = lock_idx_q;
    beat_cnt_d   = beat_cnt_q;
`ifdef RR_LOCK_WATCHDOG_EN
    stall_d      = stall_q;
    err_d        = err_q;
`endif
    if (fire) begin
      last_grant_d = out_chosen;
    end
    // BEATS is a power of two, so the counter wraps to 0 by overflow.
    if (fire && out_multibeat && (BEATS > 1)) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      if (beat_cnt_q == '0) begin
        lock_idx_d = out_chosen;
      end
    end
`ifdef RR_LOCK_WATCHDOG_EN
    // A fire in the timeout cycle wins: the stall count simply clears.
    if (fire || !locked) begin
      stall_d = '0;
    end else if (stall_q == SW'(TIMEOUT)) begin
      beat_cnt_d = '0;
      stall_d    = '0;
      err_d      = 1'b1;
    end else begin
      stall_d = stall_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= IW'(N - 1);
      lock_idx_q   <= '0;
      beat_cnt_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      lock_idx_q   <= lock_idx_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

`ifdef RR_LOCK_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end
  assign lock_timeout_err = err_q;
`else
  assign lock_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter (N=4, BEATS=4, TIMEOUT=8) against a rotating-priority reference model.
module tb_rr_lock_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int BEATS = 4;
  localparam int TO = 8;

  logic           clk;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_bits;
  logic [N-1:0]   in_multibeat;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_bits;
  logic           out_multibeat;
  logic [1:0]     out_chosen;
  logic           locked;
  logic           lock_timeout_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: last winner, beats done in current message, lock owner.
  int m_last, m_cnt, m_owner, m_stall;
  bit m_err;

  rr_lock_arbiter #(.N(N), .W(W), .BEATS(BEATS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .in_multibeat(in_multibeat),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_multibeat(out_multibeat), .out_chosen(out_chosen),
    .locked(locked), .lock_timeout_err(lock_timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic int exp_choice();
    if (m_cnt != 0) return m_owner;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (in_valid[idx]) return idx;
    end
    return N - 1;
  endfunction

  // Advance the model by one clock using current inputs, then step the DUT.
  task automatic cyc();
    int c;
    bit f, was_locked;
    c = exp_choice();
    f = in_valid[c] && out_ready;
    was_locked = (m_cnt != 0);
    if (reset) begin
      m_last = N - 1; m_cnt = 0; m_owner = 0; m_stall = 0; m_err = 0;
    end else begin
      if (f) begin
        m_last = c;
        if (in_multibeat[c]) begin
          if (m_cnt == 0) m_owner = c;
          m_cnt = (m_cnt + 1) % BEATS;
        end
      end
`ifdef RR_LOCK_WATCHDOG_EN
      if (f || !was_locked) m_stall = 0;
      else if (m_stall == TO) begin m_cnt = 0; m_stall = 0; m_err = 1; end
      else m_stall++;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Leaves input 1 locked with one beat transferred.
  task automatic lock_on_1();
    do_reset();
    in_valid = 4'b1111; in_multibeat = 4'b0010; out_ready = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    in_valid = '0; in_multibeat = '0; out_ready = 1'b1;
    do_reset();
    #1;
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_vec++; if (lock_timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", lock_timeout_err); end
    n_vec++; if (out_chosen !== 2'd3) begin n_err++; $display("FAIL reset_idle_chosen: got %0d want 3", out_chosen); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL reset_idle_ready: got %b want 1000", in_ready); end
    in_valid = 4'b1111;
    #1;
    n_vec++; if (out_chosen !== 2'd0) begin n_err++; $display("FAIL reset_first_grant: got %0d want 0", out_chosen); end
  endtask

  task automatic test_fairness();
    do_reset();
    in_valid = 4'b1111; in_multibeat = '0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_vec++; if (out_chosen !== 2'(i % 4)) begin n_err++; $display("FAIL fair_chosen[%0d]: got %0d want %0d", i, out_chosen, i % 4); end
      n_vec++; if (in_ready !== (4'b0001 << (i % 4))) begin n_err++; $display("FAIL fair_ready[%0d]: got %b want %b", i, in_ready, 4'b0001 << (i % 4)); end
      cyc();
    end
  endtask

  task automatic test_lock_hold();
    int exp_c[6] = '{0, 1, 1, 1, 1, 2};
    bit exp_l[6] = '{0, 0, 1, 1, 1, 0};
    do_reset();
    in_valid = 4'b1111; in_multibeat = 4'b0010; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_vec++; if (out_chosen !== 2'(exp_c[i])) begin n_err++; $display("FAIL hold_chosen[%0d]: got %0d want %0d", i, out_chosen, exp_c[i]); end
      n_vec++; if (locked !== exp_l[i]) begin n_err++; $display("FAIL hold_locked[%0d]: got %b want %b", i, locked, exp_l[i]); end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    lock_on_1();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = (i == 1) ? 4'b1101 : 4'b1111;
      #1;
      n_vec++; if (out_valid !== in_valid[1]) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want %b", i, out_valid, in_valid[1]); end
      n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, in_ready); end
      n_vec++; if (locked !== 1'b1 || out_chosen !== 2'd1) begin n_err++; $display("FAIL bp_lock[%0d]: got locked=%b chosen=%0d want 1/1", i, locked, out_chosen); end
      cyc();
    end
    in_valid = 4'b1111; out_ready = 1'b1;
    cyc(); cyc();
    #1;
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL bp_beat_held: got locked=%b want 1", locked); end
    cyc();
    #1;
    n_vec++; if (locked !== 1'b0 || out_chosen !== 2'd2) begin n_err++; $display("FAIL bp_release: got locked=%b chosen=%0d want 0/2", locked, out_chosen); end
  endtask

  task automatic test_owner_gap();
    lock_on_1();
    in_valid = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gap_valid[%0d]: got %b want 0", i, out_valid); end
      n_vec++; if (in_ready[3] !== 1'b0) begin n_err++; $display("FAIL gap_ready3[%0d]: got %b want 0", i, in_ready[3]); end
      n_vec++; if (out_chosen !== 2'd1) begin n_err++; $display("FAIL gap_chosen[%0d]: got %0d want 1", i, out_chosen); end
      cyc();
    end
    in_valid = 4'b1010;
    cyc(); cyc(); cyc();
    in_valid = 4'b1000; in_multibeat = '0;
    #1;
    n_vec++; if (out_chosen !== 2'd3 || locked !== 1'b0) begin n_err++; $display("FAIL gap_after: got chosen=%0d locked=%b want 3/0", out_chosen, locked); end
  endtask

  task automatic test_reset_mid_burst();
    lock_on_1();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    in_valid = 4'b0101; in_multibeat = '0;
    #1;
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL rst_mid_locked: got %b want 0", locked); end
    n_vec++; if (out_chosen !== 2'd0 || in_ready !== 4'b0001) begin n_err++; $display("FAIL rst_mid_grant: got chosen=%0d ready=%b want 0/0001", out_chosen, in_ready); end
  endtask

  task automatic test_watchdog();
    lock_on_1();
    in_valid = 4'b1101;
    for (int i = 0; i < TO - 1; i++) cyc();
    #1;
    n_vec++; if (locked !== 1'b1 || lock_timeout_err !== 1'b0) begin n_err++; $display("FAIL wd_early: got locked=%b err=%b want 1/0", locked, lock_timeout_err); end
`ifdef RR_LOCK_WATCHDOG_EN
    cyc(); cyc(); cyc();
    #1;
    n_vec++; if (locked !== 1'b0 || lock_timeout_err !== 1'b1) begin n_err++; $display("FAIL wd_fire: got locked=%b err=%b want 0/1", locked, lock_timeout_err); end
    in_multibeat = '0;
    cyc(); cyc();
    #1;
    n_vec++; if (lock_timeout_err !== 1'b1) begin n_err++; $display("FAIL wd_sticky: got %b want 1", lock_timeout_err); end
`else
    for (int i = 0; i < 3 * TO; i++) cyc();
    #1;
    n_vec++; if (locked !== 1'b1 || lock_timeout_err !== 1'b0 || out_chosen !== 2'd1) begin n_err++; $display("FAIL wd_absent: got locked=%b err=%b chosen=%0d want 1/0/1", locked, lock_timeout_err, out_chosen); end
`endif
    do_reset();
    #1;
    n_vec++; if (lock_timeout_err !== 1'b0) begin n_err++; $display("FAIL wd_reset: got %b want 0", lock_timeout_err); end
  endtask

  task automatic test_random();
    int c;
    logic [N-1:0] er;
    do_reset();
    for (int t = 0; t < 400; t++) begin
      in_valid = 4'($urandom);
      in_multibeat = 4'($urandom) | 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_bits[i*W +: W] = $urandom;
      #1;
      c = exp_choice();
      er = out_ready ? (4'b0001 << c) : 4'b0000;
      n_vec++; if (out_chosen !== 2'(c)) begin n_err++; $display("FAIL rnd_chosen[%0d]: got %0d want %0d", t, out_chosen, c); end
      n_vec++; if (out_valid !== in_valid[c] || out_bits !== in_bits[c*W +: W]) begin n_err++; $display("FAIL rnd_data[%0d]: got v=%b d=%h want v=%b d=%h", t, out_valid, out_bits, in_valid[c], in_bits[c*W +: W]); end
      n_vec++; if (in_ready !== er) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", t, in_ready, er); end
      n_vec++; if (locked !== (m_cnt != 0) || lock_timeout_err !== m_err) begin n_err++; $display("FAIL rnd_lock[%0d]: got locked=%b err=%b want %b/%b", t, locked, lock_timeout_err, m_cnt != 0, m_err); end
      cyc();
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; in_multibeat = '0; out_ready = 1'b1; in_bits = '0;
    m_last = N - 1; m_cnt = 0; m_owner = 0; m_stall = 0; m_err = 0;
    @(posedge clk); #1;
    test_reset();
    test_fairness();
    test_lock_hold();
    test_backpressure();
    test_owner_gap();
    test_reset_mid_burst();
    test_watchdog();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Parametrised round-robin arbiter with burst locking. Merges N valid/ready request channels onto one output channel.
- Once a multi-beat message starts, the grant stays locked to that input until BEATS beats have transferred.
- Successor to the fixed 4-input tile-link arbiters: generic payload width, input count and burst length, plus an optional lock watchdog.
- Sits in front of the memory/AXI bridge, merging client acquire traffic.

Parameters:
- N, 4, number of input channels (2..16).
- W, 64, payload width in bits (opaque to the arbiter).
- BEATS, 4, beats per locked message (1 disables locking; must be a power of 2).
- TIMEOUT, 255, watchdog cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  N  per-input valid
- in_ready  out  N  per-input ready
- in_bits  in  N*W  payloads; input i occupies [i*W +: W]
- in_multibeat  in  N  beat belongs to a BEATS-beat message
- out_valid  out  1  output valid
- out_ready  in  1  output ready
- out_bits  out  W  selected payload
- out_multibeat  out  1  selected in_multibeat
- out_chosen  out  clog2(N)  index of the selected input
- locked  out  1  lock currently held
- lock_timeout_err  out  1  sticky watchdog error (tied 0 when the feature is absent)

Behaviour:
- Registers and reset values (all synchronous, reset wins over any fire in the same cycle):
  - last_grant = N-1, so input 0 has top priority after reset.
  - beat_cnt = 0; lock_idx = 0; lock_timeout_err = 0.
  - locked = (beat_cnt != 0), so it is 0 after reset.
- Fire: out_valid & out_ready.
- Choice when unlocked:
  - Lowest index i > last_grant with in_valid[i].
  - Otherwise the lowest index with in_valid.
  - Otherwise N-1.
- out_chosen = locked ? lock_idx : choice.
- out_valid, out_bits and out_multibeat are muxed from out_chosen, purely combinationally (zero latency).
- out_valid never depends on out_ready.
- in_ready[i] = out_ready & (out_chosen == i). At most one in_ready is high in any cycle.
- On every fire: last_grant <= out_chosen.
- Lock counter, on a fire with out_multibeat=1 and BEATS>1:
  - beat_cnt <= beat_cnt+1, modulo BEATS.
  - If beat_cnt was 0: lock_idx <= out_chosen.
  - When beat_cnt wraps BEATS-1 -> 0, locked drops. Arbitration resumes the next cycle from last_grant = lock_idx.
- A fire with out_multibeat=0 does not change beat_cnt, including while locked. Single-beat traffic from the lock owner passes through.
- While locked, other inputs' in_valid is ignored and their in_ready stays 0, even if the owner's valid is low.
- BEATS=1: beat_cnt is held at 0, locked is constant 0, and the arbiter is pure round-robin.
- Reset mid-burst aborts the lock immediately. Upstream is responsible for resending the message.
- Multiple simultaneous valids: exactly one grant per cycle. No combinational path from in_ready back to in_valid.

Optional Feature:
- Macro: RR_LOCK_WATCHDOG_EN.
- With the macro defined:
  - stall_cnt, width clog2(TIMEOUT+1), reset 0.
  - Increments each cycle that locked=1 and there is no fire; clears on any fire or when unlocked.
  - When stall_cnt == TIMEOUT: beat_cnt <= 0 (forced unlock), stall_cnt <= 0, lock_timeout_err <= 1.
  - lock_timeout_err is sticky until reset.
  - If a fire occurs in the same cycle stall_cnt reaches TIMEOUT, the fire takes priority and no error is raised.
- Without the macro: no watchdog logic; lock_timeout_err is tied to 0 and the lock is held indefinitely.

Test Plan:
- Setup for all scenarios: N=4, BEATS=4, out_ready=1.
- Fairness: all four in_valid held high with in_multibeat=0 for 8 cycles -> out_chosen sequence 0,1,2,3,0,1,2,3. Exactly one in_ready high per cycle.
- Lock hold: input 1 sends 4 multibeat beats while inputs 0,2,3 are valid -> out_chosen = 1 for all 4 fires. locked=1 for cycles 2..4. The next grant is 2.
- Backpressure: during the lock, out_ready=0 for 3 cycles -> out_valid follows in_valid[1]. in_ready is all 0. beat_cnt holds at its value and locked stays 1.
- Owner gap: during the lock, in_valid[1]=0 for 2 cycles with input 3 valid -> out_valid=0. in_ready[3]=0. Input 3 is not granted until the burst completes.
- Reset mid-burst: assert reset after beat 2 -> locked=0, last_grant=3. With inputs 0 and 2 valid, the first grant after reset is 0.
- Watchdog (RR_LOCK_WATCHDOG_EN, TIMEOUT=8): owner stalls after beat 1 -> forced unlock after 8 stall cycles and lock_timeout_err=1 until reset. Without the macro, the lock persists and lock_timeout_err stays 0.
